mem_access_sched: RTL

MEM_ACCESS_SCHED -- requirements
Module: mem_access_sched

---
 rtl/mem_access_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_access_sched.sv
// mem_access_sched: MEM-stage access scheduler for a BRAM data memory and an IO bus.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_read_i, mem_write_i         data-memory load/store request
//   io_read_i, io_write_i           IO load/store request (priority over memory)
//   byte_or_word_i                  access size: 01 byte, 10 halfword, 00/11 word
//   unsigned_i                      zero-extend loads when 1, sign-extend when 0
//   addr_i, wdata_i                 byte address and store data
//   dmem_en_o, dmem_we_o            BRAM enable and byte write enables
//   dmem_addr_o, dmem_wdata_o       BRAM word address and replicated store data
//   dmem_rdata_i                    BRAM read data, valid one cycle after enable
//   io_req_o, io_we_o               IO request and write flag, held until ack/timeout
//   io_addr_o, io_wdata_o           IO address and write data
//   io_ack_i, io_rdata_i            IO acknowledge and read data
//   stall_o                         pipeline freeze
//   rdata_o, rdata_valid_o          load result and one-cycle valid
//   misalign_o, io_timeout_o        misaligned-access flag, one-cycle IO timeout pulse
module mem_access_sched #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        io_read_i,
    input  logic        io_write_i,
    input  logic [1:0]  byte_or_word_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_en_o,
    output logic [3:0]  dmem_we_o,
    output logic [13:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    output logic        io_req_o,
    output logic        io_we_o,
    output logic [31:0] io_addr_o,
    output logic [31:0] io_wdata_o,
    input  logic        io_ack_i,
    input  logic [31:0] io_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        io_timeout_o
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, IO_WAIT, DONE} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [7:0]  cnt;
    logic        is_byte;
    logic        is_half;
    logic        misal;
    logic        io_any;
    logic        idle;
    logic        io_go;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  mask;
    logic [31:0] sh;
    logic [31:0] ext;

    assign is_byte = byte_or_word_i == 2'b01;
    assign is_half = byte_or_word_i == 2'b10;
    assign misal   = (is_half && addr_i[0]) || (!is_byte && !is_half && addr_i[1:0] != 2'b00);
    assign io_any  = io_read_i | io_write_i;
    // Combinational outputs are gated by rst_n so reset forces them low immediately.
    assign idle    = rst_n && state == IDLE;
    assign io_go   = idle && io_any && !misal;
    assign mem_wr  = idle && !io_any && mem_write_i && !misal;
    assign mem_rd  = idle && !io_any && mem_read_i && !mem_write_i && !misal;

    assign mask = is_byte ? 4'b0001 << addr_i[1:0] :
                  is_half ? 4'b0011 << {addr_i[1], 1'b0} : 4'b1111;

    assign misalign_o   = idle && (io_any || mem_read_i || mem_write_i) && misal;
    assign dmem_en_o    = mem_wr || mem_rd;
    assign dmem_we_o    = mem_wr ? mask : 4'b0000;
    assign dmem_addr_o  = addr_i[15:2];
    assign dmem_wdata_o = is_byte ? {4{wdata_i[7:0]}} : is_half ? {2{wdata_i[15:0]}} : wdata_i;
    assign stall_o      = io_go || mem_rd || (rst_n && (state == RD_WAIT || state == IO_WAIT));

    // Align the addressed lane to bit 0, then extend according to the latched size.
    assign sh  = dmem_rdata_i >> {off_q, 3'b000};
    assign ext = size_q == 2'b01 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                 size_q == 2'b10 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            cnt           <= '0;
            io_req_o      <= 1'b0;
            io_we_o       <= 1'b0;
            io_addr_o     <= '0;
            io_wdata_o    <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            io_timeout_o  <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            io_timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_go) begin
                        io_addr_o  <= addr_i;
                        io_wdata_o <= wdata_i;
                        io_we_o    <= io_write_i;
                        io_req_o   <= 1'b1;
                        cnt        <= '0;
                        state      <= IO_WAIT;
                    end else if (mem_rd) begin
                        off_q  <= addr_i[1:0];
                        size_q <= byte_or_word_i;
                        uns_q  <= unsigned_i;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rdata_o       <= ext;
                    rdata_valid_o <= 1'b1;
                    state         <= DONE;
                end
                IO_WAIT: begin
                    // An ack wins over a coincident timeout.
                    if (io_ack_i) begin
                        io_req_o      <= 1'b0;
                        rdata_o       <= io_we_o ? rdata_o : io_rdata_i;
                        rdata_valid_o <= !io_we_o;
                        state         <= DONE;
                    end else if (cnt == LAST) begin
                        io_req_o      <= 1'b0;
                        rdata_o       <= io_we_o ? rdata_o : 32'hDEAD_BEEF;
                        rdata_valid_o <= !io_we_o;
                        io_timeout_o  <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
